// File: rtl/write_back_register_file_if.sv
// Bus bundle between the MEM/WB pipeline register / decode stage and the
// write-back register file. The master drives write-back fields and read
// addresses; the slave (register file) returns read data, the selected
// write-back value and the retired-write counter.
interface write_back_register_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  RegWriteIn;
    logic                  MemToRegIn;
    logic [DATA_WIDTH-1:0] R_Data_In;
    logic [DATA_WIDTH-1:0] ALUResult_In;
    logic [ADDR_WIDTH-1:0] rDestSelected_in;
    logic [ADDR_WIDTH-1:0] ReadAddr1;
    logic [ADDR_WIDTH-1:0] ReadAddr2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [DATA_WIDTH-1:0] WriteData_Out;
    logic [DATA_WIDTH-1:0] WriteCount;

    modport master (
        output RegWriteIn, MemToRegIn, R_Data_In, ALUResult_In,
               rDestSelected_in, ReadAddr1, ReadAddr2,
        input  ReadData1, ReadData2, WriteData_Out, WriteCount
    );

    modport slave (
        input  RegWriteIn, MemToRegIn, R_Data_In, ALUResult_In,
               rDestSelected_in, ReadAddr1, ReadAddr2,
        output ReadData1, ReadData2, WriteData_Out, WriteCount
    );
endinterface

// File: rtl/write_back_register_file.sv
// Write-back stage and 32 x 32-bit integer register file.
// Selects memory read data or ALU result for write-back, commits it to the
// register file (r0 hardwired to zero), provides two combinational read
// ports for decode and counts retired register writes.
// Optional feature macro: WB_BYPASS_EN -- when defined, a read of the
// register being written in the same cycle returns the new value
// (write-before-read); otherwise it returns the pre-write contents.
module write_back_register_file (
    input  logic                          Clock,
    input  logic                          Reset_n,
    write_back_register_file_if.slave     wb
);
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] write_count_q;
    logic [DATA_WIDTH-1:0] write_count_d;
    logic [DATA_WIDTH-1:0] write_data_c;
    logic                  commit_c;
    logic [DATA_WIDTH-1:0] read_data1_c;
    logic [DATA_WIDTH-1:0] read_data2_c;

    // Write-back select and commit qualification (r0 writes are discarded).
    always_comb begin
        write_data_c  = wb.MemToRegIn ? wb.R_Data_In : wb.ALUResult_In;
        commit_c      = wb.RegWriteIn && (wb.rDestSelected_in != ADDR_WIDTH'(0));
        write_count_d = write_count_q;
        if (commit_c) begin
            write_count_d = write_count_q + DATA_WIDTH'(1);
        end
    end

    // Register array and retired-write counter; reset clears everything.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            if (commit_c) begin
                regs_q[wb.rDestSelected_in] <= write_data_c;
            end
            write_count_q <= write_count_d;
        end
    end

    // Combinational read ports, r0 forced to zero, optional same-cycle bypass.
    always_comb begin
        read_data1_c = '0;
        read_data2_c = '0;
        if (wb.ReadAddr1 != ADDR_WIDTH'(0)) begin
            read_data1_c = regs_q[wb.ReadAddr1];
        end
        if (wb.ReadAddr2 != ADDR_WIDTH'(0)) begin
            read_data2_c = regs_q[wb.ReadAddr2];
        end
`ifdef WB_BYPASS_EN
        if (commit_c && (wb.ReadAddr1 == wb.rDestSelected_in)) begin
            read_data1_c = write_data_c;
        end
        if (commit_c && (wb.ReadAddr2 == wb.rDestSelected_in)) begin
            read_data2_c = write_data_c;
        end
`endif
    end

    assign wb.ReadData1     = read_data1_c;
    assign wb.ReadData2     = read_data2_c;
    assign wb.WriteData_Out = write_data_c;
    assign wb.WriteCount    = write_count_q;

endmodule

// File: tb/tb_write_back_register_file.sv
// Self-checking bench for write_back_register_file: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_write_back_register_file;
    logic Clock;
    logic Reset_n;

    write_back_register_file_if bus ();

    write_back_register_file dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .wb      (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int errors;
    int checks;

    // Reference model: architectural register values and retired-write count.
    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    function automatic logic [31:0] sel_value();
        return bus.MemToRegIn ? bus.R_Data_In : bus.ALUResult_In;
    endfunction

    function automatic logic [31:0] expected_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (bus.RegWriteIn && bus.rDestSelected_in != 5'd0 && addr == bus.rDestSelected_in)
            return sel_value();
`endif
        return model_regs[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_count = 32'h0;
    endtask

    // Advance one clock with the currently driven inputs and update the model.
    task automatic step();
        logic        we;
        logic [4:0]  dst;
        logic [31:0] val;
        we  = bus.RegWriteIn;
        dst = bus.rDestSelected_in;
        val = sel_value();
        @(posedge Clock);
        if (Reset_n && we && dst != 5'd0) begin
            model_regs[dst] = val;
            model_count     = model_count + 32'd1;
        end
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] dst,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus.RegWriteIn       = we;
        bus.MemToRegIn       = m2r;
        bus.R_Data_In        = rd;
        bus.ALUResult_In     = alu;
        bus.rDestSelected_in = dst;
        bus.ReadAddr1        = a1;
        bus.ReadAddr2        = a2;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        checks++;
        if (bus.WriteCount !== 32'h0) begin
            errors++; $display("FAIL reset_count actual=%h required=%h", bus.WriteCount, 32'h0);
        end
        Reset_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h12345678, 5'd5, 5'd5, 5'd5);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        checks++;
        if (bus.ReadData1 !== 32'h12345678) begin
            errors++; $display("FAIL reset_prewrite actual=%h required=%h", bus.ReadData1, 32'h12345678);
        end
        // Assert reset mid-cycle: clears without waiting for an edge.
        Reset_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (bus.ReadData1 !== 32'h0 || bus.WriteCount !== 32'h0) begin
            errors++; $display("FAIL reset_async r5=%h count=%h required=0/0", bus.ReadData1, bus.WriteCount);
        end
        // A write presented while reset is held is dropped.
        drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd6, 5'd6, 5'd5);
        checks++;
        if (bus.WriteData_Out !== 32'h77) begin
            errors++; $display("FAIL reset_wdata actual=%h required=%h", bus.WriteData_Out, 32'h77);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd5);
        checks++;
        if (bus.ReadData1 !== 32'h0 || bus.WriteCount !== 32'h0) begin
            errors++; $display("FAIL reset_dropped r6=%h count=%h required=0/0", bus.ReadData1, bus.WriteCount);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        #1;
    endtask

    task automatic test_alu_writeback();
        @(negedge Clock);
        drive(1'b1, 1'b0, 32'h0, 32'h0000002A, 5'd8, 5'd0, 5'd8);
        step();
        @(negedge Clock);
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h11111111, 5'd9, 5'd9, 5'd8);
        checks++;
        if (bus.ReadData2 !== 32'h2A || bus.WriteCount !== 32'd1) begin
            errors++; $display("FAIL alu_wb r8=%h count=%h required=0000002a/1", bus.ReadData2, bus.WriteCount);
        end
        step();
        @(negedge Clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd8);
        checks++;
        if (bus.ReadData1 !== 32'hDEADBEEF || bus.WriteCount !== 32'd2) begin
            errors++; $display("FAIL mem_wb r9=%h count=%h required=deadbeef/2", bus.ReadData1, bus.WriteCount);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge Clock);
        drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        step();
        @(negedge Clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (bus.ReadData1 !== 32'h0 || bus.WriteCount !== model_count) begin
            errors++; $display("FAIL zero_reg r0=%h count=%h required=0/%h", bus.ReadData1, bus.WriteCount, model_count);
        end
    endtask

    task automatic test_disabled_write();
        @(negedge Clock);
        drive(1'b0, 1'b0, 32'h0, 32'h55, 5'd8, 5'd8, 5'd8);
        checks++;
        if (bus.WriteData_Out !== 32'h55) begin
            errors++; $display("FAIL disabled_wdata actual=%h required=%h", bus.WriteData_Out, 32'h55);
        end
        step();
        @(negedge Clock);
        checks++;
        if (bus.ReadData1 !== 32'h2A || bus.WriteCount !== 32'd2) begin
            errors++; $display("FAIL disabled_write r8=%h count=%h required=0000002a/2", bus.ReadData1, bus.WriteCount);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] before_val;
        @(negedge Clock);
        drive(1'b1, 1'b0, 32'h0, 32'h0BADBAD0, 5'd3, 5'd3, 5'd3);
        step();
        @(negedge Clock);
        drive(1'b1, 1'b1, 32'hCAFEF00D, 32'h0, 5'd3, 5'd3, 5'd3);
`ifdef WB_BYPASS_EN
        before_val = 32'hCAFEF00D;
`else
        before_val = 32'h0BADBAD0;
`endif
        checks++;
        if (bus.ReadData1 !== before_val || bus.ReadData2 !== before_val) begin
            errors++; $display("FAIL bypass_same_cycle rd1=%h rd2=%h required=%h", bus.ReadData1, bus.ReadData2, before_val);
        end
        step();
        @(negedge Clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
        checks++;
        if (bus.ReadData1 !== 32'hCAFEF00D || bus.ReadData2 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL bypass_after_edge rd1=%h rd2=%h required=cafef00d", bus.ReadData1, bus.ReadData2);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            drive(1'b1, 1'b0, 32'h0, 32'h100 + 32'(i), 5'd12, 5'd12, 5'd13);
            step();
        end
        @(negedge Clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd0);
        checks++;
        if (bus.ReadData1 !== 32'h103 || bus.WriteCount !== model_count) begin
            errors++; $display("FAIL back_to_back r12=%h count=%h required=00000103/%h", bus.ReadData1, bus.WriteCount, model_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge Clock);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
            if (n % 7 == 0) begin
                bus.ReadAddr1 = bus.rDestSelected_in;
                #1;
            end
            checks++;
            if (bus.WriteData_Out !== sel_value() || bus.WriteCount !== model_count ||
                bus.ReadData1 !== expected_read(bus.ReadAddr1) ||
                bus.ReadData2 !== expected_read(bus.ReadAddr2)) begin
                errors++;
                $display("FAIL random[%0d] wd=%h cnt=%h rd1=%h rd2=%h required wd=%h cnt=%h rd1=%h rd2=%h",
                         n, bus.WriteData_Out, bus.WriteCount, bus.ReadData1, bus.ReadData2,
                         sel_value(), model_count, expected_read(bus.ReadAddr1), expected_read(bus.ReadAddr2));
            end
            step();
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge Clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd20, 5'd0);
        force dut.write_count_q = 32'hFFFFFFFF;
        #1;
        release dut.write_count_q;
        model_count = 32'hFFFFFFFF;
        drive(1'b1, 1'b0, 32'h0, 32'h00A5A5A5, 5'd20, 5'd20, 5'd0);
        step();
        @(negedge Clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd20, 5'd0);
        checks++;
        if (bus.WriteCount !== 32'h0 || bus.ReadData1 !== 32'h00A5A5A5) begin
            errors++; $display("FAIL counter_wrap count=%h r20=%h required=0/00a5a5a5", bus.WriteCount, bus.ReadData1);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        Reset_n = 1'b0;
        model_clear();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge Clock);
        test_reset();
        test_alu_writeback();
        test_zero_reg();
        test_disabled_write();
        test_bypass();
        test_back_to_back();
        test_random();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
